ddr_lane_sequencer: RTL
=======================

Name: ddr_lane_sequencer

Overview:
- Song-level controller for the DanceDanceRevolution light banks.
- Divides Clock into a step strobe that advances every lane bank.
- Reads one pattern row per step and issues per-lane Ren spawn pulses, so a light enters lane L0.
- Sums the signed per-lane point codes into a saturating running score; sequences idle, lead-in, play, drain and done.

Parameters:
- NUM_LANES, 4, number of light banks (lanes) driven.
- STEP_DIV, 16, Clock cycles per step (≥2); board build overrides to 12_500_000.
- PAT_LEN, 32, pattern rows per song (≥1).
- LEAD_STEPS, 4, silent steps before first pattern row.
- SCORE_W, 12, signed score width.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level, sampled each Clock; begins song from IDLE or DONE.
- pat_addr  out  $clog2(PAT_LEN)  pattern row address.
- pat_data  in  NUM_LANES  row contents, combinational from pat_addr; bit i = spawn in lane i.
- step  out  1  one-Clock strobe; clock enable for all banks.
- Ren  out  NUM_LANES  spawn request per lane; valid only in the cycle step=1.
- pt  in  4*NUM_LANES  packed signed 4-bit point code per lane; lane i at [4i+3:4i].
- score  out  SCORE_W  signed running score.
- state  out  3  current FSM state encoding.
- done  out  1  high while in DONE.

Behaviour:
- Reset (async) values: state=IDLE, divider=0, pat_addr=0, step=0, Ren=0, score=0, done=0, internal step counter=0.
- FSM states: IDLE, LEAD, PLAY, DRAIN, DONE.
  - IDLE→LEAD on Start=1.
  - DONE→LEAD on Start=1. Entering LEAD from DONE clears score and pat_addr in the same edge.
  - Start is ignored in LEAD, PLAY and DRAIN.
- Divider:
  - Runs only in LEAD, PLAY and DRAIN; forced to 0 in IDLE and DONE.
  - Counts 0..STEP_DIV-1. step=1, registered, in the cycle after the count reaches STEP_DIV-1.
  - First step occurs exactly STEP_DIV cycles after the Start-sampling edge.
- LEAD:
  - Emits LEAD_STEPS steps with Ren=0.
  - After the LEAD_STEPS-th step, moves to PLAY. With LEAD_STEPS=0, moves to PLAY directly.
- PLAY:
  - At each step, Ren=pat_data registered from current pat_addr; pat_addr increments after that step.
  - After the step for row PAT_LEN-1, pat_addr wraps to 0 and state→DRAIN.
- DRAIN:
  - Emits 5 steps (bank depth) with Ren=0 so lit notes clear, then →DONE.
- Score:
  - In the cycle step=1, in states PLAY and DRAIN, score += sign-extended sum of all NUM_LANES pt codes.
  - The sum fits in 4+$clog2(NUM_LANES)+1 bits.
  - Result saturates at +(2^(SCORE_W-1)-1) and -(2^(SCORE_W-1)); no wrap.
  - pt is ignored in LEAD, IDLE and DONE.
- Ren and step are never high outside LEAD/PLAY/DRAIN.
- Ren bits are never high without step.
- Reset mid-song aborts immediately to IDLE; score is lost.

Optional Feature:
- Macro: DDR_SEQ_PAUSE_EN.
- When defined:
  - Extra input port Pause (1 bit) is added.
  - While Pause=1 in LEAD, PLAY or DRAIN, the divider holds its value, step is suppressed and the FSM holds.
  - Release resumes the count from the held value; no step is lost or duplicated.
- When undefined: no Pause port; behaviour as above.

Decomposition:
- Shared package ddr_pkg holds:
  - state enum (IDLE, LEAD, PLAY, DRAIN, DONE);
  - PT_W=4;
  - BANK_DEPTH=5 (drain length);
  - saturating-add function.
- One sub-module: ddr_step_divider (count, enable, hold, step strobe).
- FSM, pattern addressing and score stay in ddr_lane_sequencer.

Test Plan:
- Reset mid-PLAY:
  - Stimulus: with STEP_DIV=4, assert Reset mid-PLAY.
  - Response: state=IDLE, score=0, Ren=0, step=0 in the same cycle; no step afterwards until Start.
- Start timing:
  - Stimulus: Start pulse, STEP_DIV=4, LEAD_STEPS=2, PAT_LEN=3, rows 4'b0001, 4'b1010, 4'b0000.
  - Response: steps at cycles 4, 8, 12, … Ren=0 on steps 1–2. Ren=0001, 1010, 0000 on steps 3–5. 5 drain steps with Ren=0. done=1 after step 10.
- Score accumulation:
  - Stimulus: pt lanes = +2, -1, +3, 0 held through PLAY and DRAIN (8 steps above).
  - Response: score=32 in DONE.
- Saturation:
  - Stimulus: SCORE_W=6, all lanes +7, NUM_LANES=4.
  - Response: score clamps at +31 and stays there. With all lanes -8, score clamps at -32.
- Start handling:
  - Stimulus: Start held during PLAY.
  - Response: ignored. Start in DONE clears score to 0 and re-enters LEAD with pat_addr=0.
- Pause (DDR_SEQ_PAUSE_EN builds only):
  - Stimulus: Pause=1 for 10 cycles mid-PLAY.
  - Response: next step is delayed by exactly 10 cycles; the Ren sequence is unchanged.

Source files
------------

// File: rtl/ddr_pkg.sv
// ddr_pkg: definitions shared by the DanceDanceRevolution lane sequencer.
//   ddr_state_e : song-level FSM state encoding (also driven out on `state`)
//   PT_W        : width of one signed per-lane point code
//   BANK_DEPTH  : number of lights a lane bank holds; the drain phase needs this many steps
//   sat_add     : signed add that clamps to the range of a `width`-bit signed value
package ddr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    PLAY  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ddr_state_e;

  localparam int PT_W       = 4;
  localparam int BANK_DEPTH = 5;

  // The width is passed in so one function serves every score width.
  // Working in 32-bit int keeps the intermediate sum free of overflow.
  function automatic int sat_add(input int acc, input int delta, input int width);
    int sum;
    int hi;
    int lo;
    sum = acc + delta;
    hi  = (1 << (width - 1)) - 1;
    lo  = -(1 << (width - 1));
    if (sum > hi) begin
      return hi;
    end
    if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/ddr_step_divider.sv
// ddr_step_divider: divides the system clock down to the one-cycle step strobe.
//   clk   in  : system clock
//   rst   in  : asynchronous active-high reset
//   en    in  : count while high; when low the counter is held at 0 and no step is made
//   clear in  : restart the count from 0. Takes priority over hold and counting.
//   hold  in  : freeze the count and the strobe register. The divider resumes from the held value.
//   step  out : registered strobe. It is high in the cycle after the count reaches STEP_DIV-1.
//   wrap  out : combinational. It is high at the edge that loads step=1, so the caller can register
//               data so that it lines up with the step cycle.
module ddr_step_divider #(
  parameter int STEP_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  input  logic hold,
  output logic step,
  output logic wrap
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] count_reg;
  logic             step_reg;

  assign wrap = en && !clear && !hold && (count_reg == LAST);
  assign step = step_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      step_reg  <= 1'b0;
    end else if (!en || clear) begin
      count_reg <= '0;
      step_reg  <= 1'b0;
    end else if (hold) begin
      // A pending strobe stays pending, so pausing never drops or repeats a step.
      count_reg <= count_reg;
      step_reg  <= step_reg;
    end else begin
      step_reg  <= (count_reg == LAST);
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ddr_lane_sequencer.sv
// ddr_lane_sequencer: song-level controller for the DanceDanceRevolution light banks.
// The song runs through the states IDLE -> LEAD -> PLAY -> DRAIN -> DONE. At each step in PLAY,
// the controller reads one pattern row and sends it out as per-lane spawn pulses. In PLAY and
// DRAIN it also adds the per-lane point codes into a saturating signed score.
// Optional build macro: DDR_SEQ_PAUSE_EN adds a Pause input. Pause freezes the divider, the
// step strobe and the FSM.
// Ports:
//   Clock    in  : system clock
//   Reset    in  : asynchronous active-high reset
//   Start    in  : level input; starts a song from IDLE or DONE
//   Pause    in  : (DDR_SEQ_PAUSE_EN only) hold the song in place
//   pat_addr out : pattern row address
//   pat_data in  : pattern row read combinationally from pat_addr; bit i requests a spawn in lane i
//   step     out : one-cycle strobe that acts as the clock enable for every lane bank
//   Ren      out : per-lane spawn request; it is only high together with step
//   pt       in  : packed signed 4-bit point code per lane; lane i is at [4i+3:4i]
//   score    out : signed saturating running score
//   state    out : current FSM state
//   done     out : high while the FSM is in DONE
module ddr_lane_sequencer
  import ddr_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int STEP_DIV   = 16,
  parameter int PAT_LEN    = 32,
  parameter int LEAD_STEPS = 4,
  parameter int SCORE_W    = 12,
  localparam int ADDR_W    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Start,
`ifdef DDR_SEQ_PAUSE_EN
  input  logic                      Pause,
`endif
  output logic [ADDR_W-1:0]         pat_addr,
  input  logic [NUM_LANES-1:0]      pat_data,
  output logic                      step,
  output logic [NUM_LANES-1:0]      Ren,
  input  logic [PT_W*NUM_LANES-1:0] pt,
  output logic signed [SCORE_W-1:0] score,
  output logic [2:0]                state,
  output logic                      done
);

  localparam int SUM_W   = PT_W + $clog2(NUM_LANES) + 1;
  localparam int CNT_MAX = (LEAD_STEPS > BANK_DEPTH) ? LEAD_STEPS : BANK_DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ddr_state_e                state_reg, state_next;
  logic [ADDR_W-1:0]         addr_reg, addr_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic signed [SCORE_W-1:0] score_reg, score_next;
  logic [NUM_LANES-1:0]      ren_reg;

  logic pause;
  logic div_step;
  logic div_wrap;
  logic step_fire;
  logic start_go;
  logic running_next;

  logic signed [SUM_W-1:0] lane_pt [NUM_LANES];
  logic signed [SUM_W-1:0] pt_sum;

`ifdef DDR_SEQ_PAUSE_EN
  assign pause = Pause;
`else
  assign pause = 1'b0;
`endif

  // Each lane's code is sign-extended to the sum width first, so the adder tree cannot overflow.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_pt
      assign lane_pt[gi] = SUM_W'($signed(pt[gi*PT_W +: PT_W]));
    end
  endgenerate

  always_comb begin
    pt_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pt_sum = pt_sum + lane_pt[i];
    end
  end

  // While paused, the pending strobe is masked here and kept in the divider.
  assign step_fire = div_step & ~pause;
  assign start_go  = ((state_reg == IDLE) || (state_reg == DONE)) && Start;

  // Every FSM transition happens at the edge that ends a step cycle. As a result, the state
  // seen during a step is the phase that the step belongs to.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    score_next = score_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (Start) begin
          if (LEAD_STEPS == 0) begin
            state_next = PLAY;
          end else begin
            state_next = LEAD;
          end
          addr_next  = '0;
          cnt_next   = '0;
          score_next = '0;
        end
      end
      LEAD: begin
        if (step_fire) begin
          if (int'(cnt_reg) == LEAD_STEPS - 1) begin
            state_next = PLAY;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      PLAY: begin
        if (step_fire) begin
          score_next = SCORE_W'(sat_add(int'(score_reg), int'(pt_sum), SCORE_W));
          if (int'(addr_reg) == PAT_LEN - 1) begin
            addr_next  = '0;
            state_next = DRAIN;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (step_fire) begin
          score_next = SCORE_W'(sat_add(int'(score_reg), int'(pt_sum), SCORE_W));
          if (int'(cnt_reg) == BANK_DEPTH - 1) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The divider is enabled from the next state. On entry to IDLE or DONE the count drops to 0
  // in that same edge, so no stray strobe follows the last drain step.
  assign running_next = (state_next == LEAD) || (state_next == PLAY) || (state_next == DRAIN);

  ddr_step_divider #(
    .STEP_DIV (STEP_DIV)
  ) u_divider (
    .clk   (Clock),
    .rst   (Reset),
    .en    (running_next),
    .clear (start_go),
    .hold  (pause),
    .step  (div_step),
    .wrap  (div_wrap)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      score_reg <= '0;
      ren_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      score_reg <= score_next;
      // The row is captured from the current address at the same edge that raises step.
      // The address only advances after that step cycle ends.
      if (!pause) begin
        ren_reg <= (div_wrap && (state_reg == PLAY)) ? pat_data : '0;
      end
    end
  end

  assign step     = step_fire;
  assign Ren      = step_fire ? ren_reg : '0;
  assign pat_addr = addr_reg;
  assign score    = score_reg;
  assign state    = state_reg;
  assign done     = (state_reg == DONE);

endmodule
